reg_file_reader: RTL
====================

# reg_file_reader

Multi-entry register file that adds the consumer side to the team's single `Register` write path: one enable-qualified write port plus two independent registered read ports with a valid/ready handshake. Sits between writeback and the CGRA operand-fetch stage. Each read port snapshots the addressed entry one cycle after a request and holds it until the consumer accepts it.

## Interface
- `XLEN`, default 32: data width.
- `NREGS`, default 32: number of entries; entry 0 is hardwired to zero.
- `AW`, default 5: address width, `$clog2(NREGS)`.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `r_enable`  in  1  write strobe.
- `wr_addr`  in  AW  write address.
- `data_in`  in  XLEN  write data.
- `rd_req_a`, `rd_req_b`  in  1  read request, one per port.
- `rd_addr_a`, `rd_addr_b`  in  AW  read address.
- `rd_req_ready_a`, `rd_req_ready_b`  out  1  port can accept a request this cycle.
- `rd_valid_a`, `rd_valid_b`  out  1  read data valid.
- `rd_ready_a`, `rd_ready_b`  in  1  consumer accepts the data.
- `rd_data_a`, `rd_data_b`  out  XLEN  read data.

## Operation
- Reset:
  - Asserted at any time, it clears all entries to 0, `rd_valid_*` to 0 and `rd_data_*` to 0.
  - `rd_req_ready_*` is 1 during and after reset.
  - A reset in the middle of a transaction discards pending reads.
- Write:
  - On a rising edge with `r_enable`=1 and `wr_addr`≠0, the entry takes `data_in`.
  - Writes to address 0 are dropped.
  - Addresses ≥ NREGS are dropped.
- Request accept, per port: a request is accepted on an edge where `rd_req`=1 and `rd_req_ready`=1.
  - `rd_req_ready = !rd_valid || rd_ready`, combinational.
  - Each port holds one entry of buffering.
- Port state machine, per port, two states:
  - IDLE (`rd_valid`=0).
  - HOLD (`rd_valid`=1).
  - IDLE→HOLD on an accepted request.
  - HOLD→HOLD on `rd_ready`=1 together with a new accepted request; this is back-to-back, and the data is replaced.
  - HOLD→IDLE on `rd_ready`=1 with no request.
  - HOLD stays HOLD with data frozen while `rd_ready`=0.
- Snapshot: `rd_data` is captured at accept and does not track later writes to the same entry.
- Address 0 returns 0.
- Address ≥ NREGS returns 0.
- Ports A and B are fully independent. Both may read the same address in the same cycle.

## Timing
- Read latency is 1 cycle: a request accepted at edge N gives `rd_valid`=1 with data after edge N.
- Throughput is one read per port per cycle while `rd_ready` stays 1.
- A write becomes visible to a request accepted on the next edge.
- Write and read of the same nonzero address on the same edge: behaviour is set by the macro below.
- `rd_req` while `rd_req_ready`=0 is ignored, not queued. The requester must hold it.

## Configuration
- `REG_FILE_BYPASS_EN` defined:
  - A same-edge write and accepted read to the same nonzero address returns the new `data_in`.
  - This is write-to-read forwarding.
- Not defined:
  - The same case returns the pre-write value.
  - The new value is seen by the next request.

## Structure
- Shared package `reg_file_pkg`:
  - constants `XLEN_DEF`, `NREGS_DEF`;
  - typedefs `rf_addr_t` and `rf_data_t`;
  - the port-state enum `rd_state_e` {IDLE, HOLD}.
- Sub-module `reg_file_rd_port`:
  - the per-port handshake, state machine and data register;
  - instantiated twice, with the storage array and bypass mux in the top level.

## Test plan
- Reset mid-run: write x5=A5A5A5A5, then assert `reset` between edges → `rd_valid_*`=0 immediately. After release, a read of x5 returns 00000000.
- Basic write/read: write x3=A5A5A5A5; next cycle port A reads x3 → `rd_valid_a`=1 one cycle later, `rd_data_a`=A5A5A5A5.
- x0 protection: write x0=12345678, then read x0 on both ports → both return 00000000.
- Backpressure and snapshot: port B reads x7=5A5A5A5A with `rd_ready_b`=0 for 3 cycles, while x7 is rewritten to 11111111.
  - `rd_req_ready_b`=0 throughout the stall.
  - `rd_data_b` stays 5A5A5A5A.
  - Raising `rd_ready_b` gives one accept, then IDLE.
- Back-to-back reads: port A streams x1, x2, x3 (values 1, 2, 3) with `rd_ready_a`=1 → `rd_data_a` gives 1, 2, 3 on consecutive cycles with `rd_valid_a` held at 1.
- Bypass: x9 holds 0, then write x9=DEADBEEF on the same edge as a port A read of x9.
  - With `REG_FILE_BYPASS_EN`: returns DEADBEEF.
  - Without the macro: returns 00000000, and the next read returns DEADBEEF.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the register file and its read ports.
// The REG_FILE_BYPASS_EN macro (see reg_file_reader) needs nothing from here.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [$clog2(NREGS_DEF)-1:0] rf_addr_t;
  typedef logic [XLEN_DEF-1:0]          rf_data_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: accepts a request, snapshots the supplied entry and
// holds it under valid/ready until the consumer takes it.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic            ready_i,
  output logic            req_ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);

  rd_state_e       state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            accept;

  // The single buffer slot frees up in the same cycle the consumer drains it.
  assign req_ready_o = (state_q == IDLE) || ready_i;
  assign accept      = req_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HOLD;
          data_d  = rdata_i;
        end
      end
      HOLD: begin
        if (accept) begin
          data_d = rdata_i;
        end else if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == HOLD);
  assign data_o  = data_q;

endmodule

// File: rtl/reg_file_reader.sv
// Register file with one write port and two independent registered read ports.
// Define REG_FILE_BYPASS_EN to forward same-edge write data to an accepted read.
module reg_file_reader
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            r_enable,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] data_in,
  input  logic            rd_req_a,
  input  logic            rd_req_b,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic            rd_req_ready_a,
  output logic            rd_req_ready_b,
  output logic            rd_valid_a,
  output logic            rd_valid_b,
  input  logic            rd_ready_a,
  input  logic            rd_ready_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] rdSnapA, rdSnapB;
  logic            wrEn;

  function automatic logic inRange(input logic [AW-1:0] a);
    return int'({1'b0, a}) < NREGS;
  endfunction

  assign wrEn = r_enable && (wr_addr != '0) && inRange(wr_addr);

  // Entry 0 is never written, so it reads back as the reset value of zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrEn) begin
      regs_q[wr_addr] <= data_in;
    end
  end

  always_comb begin
    rdSnapA = '0;
    rdSnapB = '0;
    if ((rd_addr_a != '0) && inRange(rd_addr_a)) rdSnapA = regs_q[rd_addr_a];
    if ((rd_addr_b != '0) && inRange(rd_addr_b)) rdSnapB = regs_q[rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
    if (wrEn && (wr_addr == rd_addr_a)) rdSnapA = data_in;
    if (wrEn && (wr_addr == rd_addr_b)) rdSnapB = data_in;
`endif
  end

  reg_file_rd_port #(.XLEN(XLEN)) u_port_a (
    .clk_i       (clock),
    .rst_i       (reset),
    .req_i       (rd_req_a),
    .rdata_i     (rdSnapA),
    .ready_i     (rd_ready_a),
    .req_ready_o (rd_req_ready_a),
    .valid_o     (rd_valid_a),
    .data_o      (rd_data_a)
  );

  reg_file_rd_port #(.XLEN(XLEN)) u_port_b (
    .clk_i       (clock),
    .rst_i       (reset),
    .req_i       (rd_req_b),
    .rdata_i     (rdSnapB),
    .ready_i     (rd_ready_b),
    .req_ready_o (rd_req_ready_b),
    .valid_o     (rd_valid_b),
    .data_o      (rd_data_b)
  );

endmodule
